// File: rtl/i2s_rx_slave.sv
// Slave-side I2S receiver: oversamples SCK/WS/SD in clk_i and emits one right-aligned word per slot.
// Define I2S_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single holding register.
module i2s_rx_slave #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  fmt_i,
  input  logic [1:0]  chl_i,
  input  logic        pol_i,
  input  logic        sck_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [31:0] data_o,
  output logic        chn_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        ovf_o,
  output logic        err_o
);

`ifdef I2S_RX_FIFO_EN
  localparam int unsigned DEPTH = FIFO_DEPTH;
`else
  localparam int unsigned DEPTH = (FIFO_DEPTH > 1) ? 1 : FIFO_DEPTH;
`endif
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, DONE} state_e;

  logic [2:0]  sck_q;
  logic [1:0]  ws_sync_q, sd_sync_q;
  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sh_q, sh_d;
  logic        chn_q, chn_d;
  logic [1:0]  fmt_q, fmt_d, len_q, len_d;
  logic        pol_q, pol_d;
  logic        ws_prev_q, ws_prev_d, ws_vld_q, ws_vld_d;
  logic        err_q, err_d, ovf_q, ovf_d;

  logic        ws_s, sd_s, strobe, boundary, start, push, is_lsb, is_i2s;
  logic [5:0]  n_bits, cnt_inc;
  logic [31:0] mask, shifted, push_data;

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          pop, full, wr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q     <= '0;
      ws_sync_q <= '0;
      sd_sync_q <= '0;
    end else begin
      sck_q     <= {sck_q[1:0], sck_i};
      ws_sync_q <= {ws_sync_q[0], ws_i};
      sd_sync_q <= {sd_sync_q[0], sd_i};
    end
  end

  always_comb begin
    ws_s     = ws_sync_q[1];
    sd_s     = sd_sync_q[1];
    strobe   = pol_q ? (sck_q[2] & ~sck_q[1]) : (~sck_q[2] & sck_q[1]);
    boundary = strobe & ws_vld_q & (ws_s != ws_prev_q);
    n_bits   = {1'b0, len_q, 3'b000} + 6'd8;
    mask     = (len_q == 2'b11) ? '1 : ((32'd1 << n_bits) - 32'd1);
    shifted  = {sh_q[30:0], sd_s};
    cnt_inc  = bit_cnt_q + 6'd1;
    is_lsb   = (fmt_q == 2'b10);
    is_i2s   = (fmt_q[1] == fmt_q[0]);
  end

  // I2S: the strobe that shows the WS change still carries the previous word's LSB,
  // so it closes the old slot and the new MSB is taken on the next strobe (SKIP).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    chn_d     = chn_q;
    fmt_d     = fmt_q;
    len_d     = len_q;
    pol_d     = pol_q;
    ws_prev_d = strobe ? ws_s : ws_prev_q;
    ws_vld_d  = ws_vld_q | strobe;
    start     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    err_d     = 1'b0;
    if (!en_i) begin
      state_d  = IDLE;
      ws_vld_d = 1'b0;
      pol_d    = pol_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          pol_d   = pol_i;
        end
        SYNC: begin
          pol_d = pol_i;
          start = boundary;
        end
        SKIP: begin
          if (boundary) begin
            start = 1'b1;
          end else if (strobe) begin
            sh_d      = {31'b0, sd_s};
            bit_cnt_d = 6'd1;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (boundary) begin
            start = 1'b1;
            if (is_lsb) begin
              if (bit_cnt_q >= n_bits) begin
                push      = 1'b1;
                push_data = sh_q & mask;
              end else begin
                err_d = 1'b1;
              end
            end else if (is_i2s && (cnt_inc == n_bits)) begin
              push      = 1'b1;
              push_data = shifted;
            end else begin
              err_d = 1'b1;
            end
          end else if (strobe) begin
            sh_d      = shifted;
            bit_cnt_d = (bit_cnt_q == 6'd32) ? bit_cnt_q : cnt_inc;
            if (!is_lsb && (cnt_inc == n_bits)) begin
              push      = 1'b1;
              push_data = shifted;
              state_d   = DONE;
            end
          end
        end
        DONE:    start = boundary;
        default: state_d = IDLE;
      endcase
      if (start) begin
        chn_d = ws_s;
        fmt_d = fmt_i;
        len_d = chl_i;
        pol_d = pol_i;
        if (fmt_i[1] ^ fmt_i[0]) begin
          sh_d      = {31'b0, sd_s};
          bit_cnt_d = 6'd1;
          state_d   = SHIFT;
        end else begin
          sh_d      = '0;
          bit_cnt_d = '0;
          state_d   = SKIP;
        end
      end
    end
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop      = (fill_q != '0) & ready_i;
    full     = (fill_q == (AW+1)'(DEPTH));
    wr       = push & (!full | pop);
    ovf_d    = push & full & !pop;
    wr_ptr_d = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q;
    if (wr && !pop)      fill_d = fill_q + 1'b1;
    else if (!wr && pop) fill_d = fill_q - 1'b1;
    if (!en_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      chn_q     <= 1'b0;
      fmt_q     <= '0;
      len_q     <= '0;
      pol_q     <= 1'b0;
      ws_prev_q <= 1'b0;
      ws_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      chn_q     <= chn_d;
      fmt_q     <= fmt_d;
      len_q     <= len_d;
      pol_q     <= pol_d;
      ws_prev_q <= ws_prev_d;
      ws_vld_q  <= ws_vld_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      if (wr) mem_q[wr_ptr_q] <= {chn_q, push_data};
    end
  end

  assign valid_o         = (fill_q != '0);
  assign {chn_o, data_o} = mem_q[rd_ptr_q];
  assign ovf_o           = ovf_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Scoreboard bench for i2s_rx_slave: directed serial slots, monitor pops expected words on handshake.
module tb_i2s_rx_slave;
`ifdef I2S_RX_FIFO_EN
  localparam int EXP_DEPTH = 4;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, en, pol, sck, ws, sd, ready;
  logic [1:0]  fmt, chl;
  logic [31:0] data_o;
  logic        chn_o, valid_o, ovf_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  int err_cnt  = 0;
  logic [32:0] exp_q[$];
  logic        bws[$];
  logic        bsd[$];

  always #5 clk = ~clk;

  i2s_rx_slave #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fmt_i(fmt), .chl_i(chl), .pol_i(pol),
    .sck_i(sck), .ws_i(ws), .sd_i(sd), .data_o(data_o), .chn_o(chn_o),
    .valid_o(valid_o), .ready_i(ready), .ovf_o(ovf_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (ovf_o) ovf_cnt++;
      if (err_o) err_cnt++;
      if (valid_o && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got chn %0d data 0x%0h, required no word", chn_o, data_o);
        end else begin
          e = exp_q.pop_front();
          check("word", {31'b0, chn_o, data_o}, {31'b0, e});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached with %0d words outstanding", exp_q.size());
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic restart(input logic [1:0] f, input logic [1:0] c, input logic p);
    en  = 1'b0;
    fmt = f;
    chl = c;
    pol = p;
    sck = p;
    step(4);
    en = 1'b1;
    step(2);
  endtask

  // Append one slot: n data bits MSB first, left-aligned (lsb=0) or right-aligned (lsb=1), rest random.
  task automatic add_slot(input logic w, input int len, input int n, input logic [31:0] word, input bit lsb);
    for (int i = 0; i < len; i++) begin
      int   pos;
      logic b;
      pos = lsb ? i - (len - n) : i;
      if (pos >= 0 && pos < n) b = word[n-1-pos];
      else                     b = 1'($urandom_range(0, 1));
      bws.push_back(w);
      bsd.push_back(b);
    end
  endtask

  // I2S delays SD by one bit against WS; one SCK period = 8 clk.
  task automatic play(input bit i2s);
    for (int t = 0; t < bws.size(); t++) begin
      ws = bws[t];
      sd = i2s ? ((t == 0) ? 1'b0 : bsd[t-1]) : bsd[t];
      #40 sck = ~sck;
      #40 sck = ~sck;
    end
    bws.delete();
    bsd.delete();
    step(10);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(1);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int e0, o0;
    rst = 1'b1; en = 1'b0; ready = 1'b0; fmt = '0; chl = '0; pol = 1'b0;
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_chn", chn_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_err", err_o, 0);
    step(1);
    rst = 1'b0;
    step(2);

    // I2S, N=16, 16-bit slots
    restart(2'b00, 2'b01, 1'b0);
    ready = 1'b1;
    e0 = err_cnt;
    exp_q.push_back({1'b0, 32'h0000A5C3});
    exp_q.push_back({1'b1, 32'h00001234});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 16, 16, 32'hA5C3, 0);
    add_slot(1'b1, 16, 16, 32'h1234, 0);
    add_slot(1'b0, 4, 0, '0, 0);
    play(1);
    drain("i2s_drain");
    check("i2s_err", err_cnt - e0, 0);

    // MSB-justified, N=24, 32-bit slot with junk tail
    restart(2'b01, 2'b10, 1'b0);
    e0 = err_cnt;
    exp_q.push_back({1'b0, 32'h00ABCDEF});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 32, 24, 32'hABCDEF, 0);
    add_slot(1'b1, 4, 0, '0, 0);
    play(0);
    drain("msb24_drain");
    check("msb24_err", err_cnt - e0, 0);

    // LSB-justified, N=16, 32-bit slot with leading junk
    restart(2'b10, 2'b01, 1'b0);
    e0 = err_cnt;
    exp_q.push_back({1'b0, 32'h0000BEEF});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 32, 16, 32'hBEEF, 1);
    add_slot(1'b1, 4, 0, '0, 0);
    play(0);
    drain("lsb16_drain");
    check("lsb16_err", err_cnt - e0, 0);

    // MSB-justified, N=8, sampled on SCK fall
    restart(2'b01, 2'b00, 1'b1);
    e0 = err_cnt;
    exp_q.push_back({1'b0, 32'h0000003C});
    exp_q.push_back({1'b1, 32'h000000C3});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 8, 8, 32'h3C, 0);
    add_slot(1'b1, 8, 8, 32'hC3, 0);
    play(0);
    drain("pol1_drain");
    check("pol1_err", err_cnt - e0, 0);

    // Short I2S slot: 8 of 16 bits, then a full right slot
    restart(2'b00, 2'b01, 1'b0);
    e0 = err_cnt;
    exp_q.push_back({1'b1, 32'h00005A5A});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 8, 8, 32'hAB, 0);
    add_slot(1'b1, 16, 16, 32'h5A5A, 0);
    add_slot(1'b0, 4, 0, '0, 0);
    play(1);
    drain("short_drain");
    check("short_err", err_cnt - e0, 1);

    // Overflow: six words with ready low
    restart(2'b01, 2'b01, 1'b0);
    ready = 1'b0;
    o0 = ovf_cnt;
    e0 = err_cnt;
    add_slot(1'b1, 4, 0, '0, 0);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w;
      w = 32'h1001 * (k + 1);
      add_slot(1'(k % 2), 16, 16, w, 0);
      if (k < EXP_DEPTH) exp_q.push_back({1'(k % 2), w});
    end
    play(0);
    @(negedge clk);
    check("ovf_count", ovf_cnt - o0, 6 - EXP_DEPTH);
    check("ovf_valid", valid_o, 1);
    step(1);
    ready = 1'b1;
    drain("ovf_drain");
    check("ovf_err", err_cnt - e0, 0);

    // en_i dropped mid-slot with a word held
    ready = 1'b0;
    restart(2'b00, 2'b01, 1'b0);
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 16, 16, 32'h1111, 0);
    add_slot(1'b1, 6, 0, '0, 0);
    play(1);
    @(negedge clk);
    check("en_held_valid", valid_o, 1);
    check("en_held_data", data_o, 32'h1111);
    step(1);
    en = 1'b0;
    step(1);
    @(negedge clk);
    check("en_flush_valid", valid_o, 0);
    ready = 1'b1;
    step(5);
    restart(2'b00, 2'b01, 1'b0);
    exp_q.push_back({1'b0, 32'h00002222});
    exp_q.push_back({1'b1, 32'h00003333});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 16, 16, 32'h2222, 0);
    add_slot(1'b1, 16, 16, 32'h3333, 0);
    add_slot(1'b0, 4, 0, '0, 0);
    play(1);
    drain("en_restart_drain");

    // rst_i pulsed mid-slot with a word held
    ready = 1'b0;
    restart(2'b00, 2'b01, 1'b0);
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 16, 16, 32'h4444, 0);
    add_slot(1'b1, 6, 0, '0, 0);
    play(1);
    @(negedge clk);
    check("rst_held_valid", valid_o, 1);
    step(1);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_data", data_o, 0);
    step(1);
    rst = 1'b0;
    ready = 1'b1;
    step(3);
    exp_q.push_back({1'b0, 32'h00005555});
    add_slot(1'b1, 4, 0, '0, 0);
    add_slot(1'b0, 16, 16, 32'h5555, 0);
    add_slot(1'b1, 4, 0, '0, 0);
    play(1);
    drain("rst_restart_drain");

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
